msp430_clock_gate_bank: RTL
===========================

# msp430_clock_gate_bank

Multi-channel clock gate controller for the MSP430 core. It gives each of NCH peripheral or sub-block clock domains a glitch-free gated clock, built from a low-transparent latch and an AND gate. A per-channel request/acknowledge FSM sits in front of each gate and adds idle-timeout hysteresis, so short gaps in a request do not toggle the gate. It sits between the clock module (`clk`) and the gated consumers, and replaces single-enable gating where wake handshakes and delayed shut-off are needed.

## Interface
- `NCH`, 4: number of independent gated-clock channels (1..16).
- `IDLE_CYCLES`, 8: extra gated cycles kept after a channel's demand drops (0..255). The internal counter width is `max(1, clog2(IDLE_CYCLES+1))`.

Ports:
- `clk`  in  1  source clock; FSM and counters run on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `scan_enable`  in  1  forces every gate open during scan shift; the FSM is unaffected.
- `req`  in  NCH  per-channel clock request, synchronous to `clk`.
- `force_on`  in  NCH  per-channel override; holds the channel in ON while high.
- `gclk`  out  NCH  gated clocks: `gclk[i] = clk & latch[i]`.
- `ack`  out  NCH  high while the channel's gated clock is guaranteed running (ON or HOLD).
- `gate_en`  out  NCH  registered gate enable (pre-latch); used for status and debug.
- `all_off`  out  1  high when every channel is in OFF.

## Operation
- Per-channel demand: `dem[i] = req[i] | force_on[i]`.
- Each channel has its own FSM state, `en_reg`, and idle counter `cnt`. There is no coupling between channels.
- The latch is transparent while `clk` = 0 and its input is `en_reg[i] | scan_enable`. `gclk[i]` can therefore never be truncated or glitched.
- FSM states and transitions:
  - OFF: `en_reg`=0, `ack`=0. If `dem` is high → WAKE, and `en_reg`←1.
  - WAKE (lasts exactly 1 cycle): `en_reg`=1, `ack`=0. Always → ON. A `dem` drop during WAKE is ignored.
  - ON: `en_reg`=1, `ack`=1. If `dem` is low:
    - with `IDLE_CYCLES` > 0 → HOLD, `cnt`←`IDLE_CYCLES`−1;
    - with `IDLE_CYCLES` = 0 → OFF, `en_reg`←0.
  - HOLD: `en_reg`=1, `ack`=1. The checks are taken in this priority order:
    - `dem` high → ON, `cnt`←0;
    - else `cnt`=0 → OFF, `en_reg`←0;
    - else `cnt`←`cnt`−1.
- `gate_en` equals `en_reg`. `all_off` is the AND over all channels of (state == OFF), and is registered.
- `scan_enable` does not alter the state, counters, `ack` or `all_off`.

## Timing
- Reset (asynchronous, with `reset_n` low):
  - all states go to OFF; `en_reg`=0, `cnt`=0, `ack`=0, `gate_en`=0, `all_off`=1;
  - latches hold 0 unless `scan_enable` is high.
- Reset asserted mid-operation:
  - `en_reg` drops immediately;
  - a `gclk` high phase already in progress completes in full;
  - no further `gclk` pulses occur from the next `clk` low phase onward.
- Release: the first FSM update happens at the first `clk` rising edge with `reset_n` high.
- Wake latency (`dem` sampled high at edge N while in OFF):
  - `en_reg` rises after N;
  - the first `gclk` rising edge is at N+1;
  - `ack` rises after N+1, aligned with that first gated edge.
- Shut-off (`dem` sampled low at edge M while in ON):
  - gated rising edges continue at M+1 … M+`IDLE_CYCLES`;
  - `ack`, `gate_en` and the state fall after edge M+`IDLE_CYCLES`;
  - no gated edge occurs after that.
  - With `IDLE_CYCLES`=0, the last gated edge is M.
- Re-request in HOLD at edge K: return to ON after K, with no missing gated edge and no `ack` drop.
- `dem` high at the same edge where `cnt` reaches 0: re-request wins; the channel stays ON.
- `force_on` held high: the channel never leaves ON, regardless of `req`.
- Back-to-back: a channel that reaches OFF and sees `dem` high at the next edge re-runs WAKE (1 cycle with `ack`=0).

## Test plan
- Reset with `req`=4'b1111: `gclk`=0, `ack`=0, `all_off`=1. After release, `ack` rises 2 edges after `req` is sampled; the first gated edge coincides with the `ack` rise.
- `IDLE_CYCLES`=8, `req[0]` pulses high then drops at edge M: exactly 8 further `gclk[0]` rising edges; `ack[0]` low after M+8; channels 1–3 stay static.
- Drop `req[1]` then re-assert after 3 cycles (within HOLD): `gclk[1]` has no missing edge and `ack[1]` stays high throughout.
- `scan_enable`=1 with all `req`=0: every `gclk` toggles with `clk`; `ack`=0, `all_off`=1 unchanged; no latch-output changes while `clk`=1.
- `reset_n` dropped while `clk` is high with channel 2 ON: the current `gclk[2]` high phase completes, then no pulses follow; after release, state is OFF.
- `IDLE_CYCLES`=0 build with `force_on[3]` toggled: channel 3 is OFF the cycle after demand drops, with last gated edge M; `force_on` high keeps `ack[3]`=1 while `req[3]`=0.

Source files
------------

// File: rtl/msp430_clock_gate_bank.sv
// Multi-channel glitch-free clock gate bank: per-channel wake/hold FSM
// drives a low-transparent latch + AND gate, with idle-timeout hysteresis.
module msp430_clock_gate_bank #(
  parameter int NCH         = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           scan_enable,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] force_on,
  output logic [NCH-1:0] gclk,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] gate_en,
  output logic           all_off
);

  localparam int CW = ($clog2(IDLE_CYCLES + 1) > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = (IDLE_CYCLES > 0) ? CW'(IDLE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [CW-1:0]   cnt_q   [NCH];
  logic [CW-1:0]   cnt_d   [NCH];
  logic [NCH-1:0]  en_q, en_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            all_off_q, all_off_d;
  logic [NCH-1:0]  lat_q;
  logic [NCH-1:0]  dem;

  assign dem = req | force_on;

  always_comb begin
    en_d      = en_q;
    ack_d     = '0;
    all_off_d = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_OFF: begin
          if (dem[i]) begin
            state_d[i] = S_WAKE;
            en_d[i]    = 1'b1;
          end
        end
        // WAKE always advances; a demand drop here is deliberately ignored
        S_WAKE: begin
          state_d[i] = S_ON;
        end
        S_ON: begin
          if (!dem[i]) begin
            if (IDLE_CYCLES > 0) begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = HOLD_LOAD;
            end else begin
              state_d[i] = S_OFF;
              en_d[i]    = 1'b0;
            end
          end
        end
        S_HOLD: begin
          // Re-request takes priority over an expiring counter
          if (dem[i]) begin
            state_d[i] = S_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = S_OFF;
            en_d[i]    = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: begin
          state_d[i] = S_OFF;
          en_d[i]    = 1'b0;
        end
      endcase
      ack_d[i] = (state_d[i] == S_ON) || (state_d[i] == S_HOLD);
      if (state_d[i] != S_OFF) all_off_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      en_q      <= '0;
      ack_q     <= '0;
      all_off_q <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q      <= en_d;
      ack_q     <= ack_d;
      all_off_q <= all_off_d;
    end
  end

  // Latch only follows the enable while clk is low, so a high phase is never cut
  always_latch begin
    if (!clk) lat_q <= en_q | {NCH{scan_enable}};
  end

  assign gclk    = {NCH{clk}} & lat_q;
  assign ack     = ack_q;
  assign gate_en = en_q;
  assign all_off = all_off_q;

endmodule
